// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use/redirect hazard control and mult/div busy/done sequencing for a 5-stage MIPS pipe.
module pipe_hazard_ctrl #(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_hilo,
  input  logic             id_is_md,
  input  logic             exe_mem_read,
  input  logic [4:0]       exe_rt,
  input  logic             md_start,
  input  logic             md_is_div,
  input  logic             redirect,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic [2:0]       id_exe_write,
  output logic             md_busy,
  output logic             md_done,
  output logic             md_err,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam int LW = $clog2(DIV_LAT > MULT_LAT ? DIV_LAT : MULT_LAT) + 1;
  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;
  md_state_e        state_q, state_d;
  logic [LW-1:0]    cnt_q, cnt_d, lat_m2;
  logic             busy_q, done_q, err_q, err_d, start_ok;
  logic             lu, ms, stall;
  logic [CNT_W-1:0] stall_q;
  assign lu = exe_mem_read & (exe_rt != 5'd0) &
              ((id_uses_rs & (id_rs == exe_rt)) | (id_uses_rt & (id_rt == exe_rt)));
  assign ms = (busy_q | md_start) & (id_is_hilo | id_is_md);
  assign stall = (lu | ms) & ~redirect;
  assign pc_write     = redirect | ~(lu | ms);
  assign if_id_write  = redirect | ~(lu | ms);
  assign if_id_flush  = redirect;
  assign id_exe_write = {3{~redirect & ~(lu | ms)}};
  assign md_busy      = busy_q;
  assign md_done      = done_q;
  assign md_err       = err_q;
  assign stall_cycles = stall_q;
  // cnt holds the BUSY cycles still to run; the issue and DONE cycles make up the other two of LAT
  assign lat_m2   = md_is_div ? LW'(DIV_LAT - 2) : LW'(MULT_LAT - 2);
  assign start_ok = md_start & (state_q != MD_BUSY);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q | (md_start & (state_q == MD_BUSY));
    if (start_ok) begin
      state_d = (lat_m2 == '0) ? MD_DONE : MD_BUSY;
      cnt_d   = lat_m2;
    end else if (state_q == MD_BUSY) begin
      state_d = (cnt_q == LW'(1)) ? MD_DONE : MD_BUSY;
      cnt_d   = cnt_q - LW'(1);
    end else if (state_q == MD_DONE) begin
      state_d = MD_IDLE;
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= state_d != MD_IDLE;
      done_q  <= state_d == MD_DONE;
      err_q   <= err_d;
      if (stall && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
    end
  end
endmodule
